// File: rtl/harvard_pkg.sv
// harvard_pkg: shared widths and the pending-write entry type for the writeback stage.
package harvard_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_regfile_stage_if.sv
// wb_regfile_stage_if: ALU-result handshake, stall, read ports and status of the writeback stage.
interface wb_regfile_stage_if
    import harvard_pkg::*;
#(
    parameter int DATA_W = harvard_pkg::DATA_W,
    parameter int ADDR_W = harvard_pkg::ADDR_W,
    parameter int DEPTH  = harvard_pkg::DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_dest;
    logic              wb_stall;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [CW-1:0]     buf_count;
    logic [15:0]       retire_count;

    modport master (
        output in_valid, in_data, in_dest, wb_stall, rd_addr_a, rd_addr_b,
        input  in_ready, rd_data_a, rd_data_b, buf_count, retire_count
    );
    modport slave (
        input  in_valid, in_data, in_dest, wb_stall, rd_addr_a, rd_addr_b,
        output in_ready, rd_data_a, rd_data_b, buf_count, retire_count
    );
endinterface

// File: rtl/wb_skid_fifo.sv
// wb_skid_fifo: pending-write FIFO kept in age order (index 0 oldest) so the
// forwarding mux can scan every live entry.
module wb_skid_fifo
    import harvard_pkg::*;
#(
    parameter int DEPTH = harvard_pkg::DEPTH,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  logic      pop_i,
    input  wb_entry_t din_i,
    output logic [CW-1:0] count_o,
    output wb_entry_t entries_o [DEPTH]
);
    logic [CW-1:0] count_q, count_d, wr_idx;
    wb_entry_t     entries_q [DEPTH];
    wb_entry_t     entries_d [DEPTH];
    logic          push, pop;

    assign pop    = pop_i && count_q != '0;
    assign push   = push_i && count_q != CW'(DEPTH);
    assign wr_idx = count_q - CW'(pop);

    // Pop shifts everything toward index 0; a same-edge push lands behind the survivors.
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < DEPTH - 1; i++)
            entries_d[i] = pop ? entries_q[i+1] : entries_q[i];
        for (int i = 0; i < DEPTH; i++)
            if (push && CW'(i) == wr_idx) entries_d[i] = din_i;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    assign count_o   = count_q;
    assign entries_o = entries_q;
endmodule

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: buffers ALU results, drains them into the register file and
// forwards still-pending writes to both read ports.
module wb_regfile_stage
    import harvard_pkg::*;
#(
    parameter int DATA_W = harvard_pkg::DATA_W,
    parameter int ADDR_W = harvard_pkg::ADDR_W,
    parameter int DEPTH  = harvard_pkg::DEPTH
) (
    input logic clk,
    input logic reset,
    wb_regfile_stage_if.slave bus
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NREG = 2 ** ADDR_W;

    logic [CW-1:0]     count;
    wb_entry_t         entries [DEPTH];
    wb_entry_t         din;
    logic              push, pop;
    logic [DATA_W-1:0] regfile_q [NREG];
    logic [15:0]       retire_q;
    logic [DATA_W-1:0] rd_a, rd_b;

    assign din          = '{dest: bus.in_dest, data: bus.in_data};
    assign bus.in_ready = count != CW'(DEPTH);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = count != '0 && !bus.wb_stall;

    wb_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .pop_i     (pop),
        .din_i     (din),
        .count_o   (count),
        .entries_o (entries)
    );

    // Writes to r0 are dropped but still count as retired.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
            for (int i = 0; i < NREG; i++) regfile_q[i] <= '0;
        end else if (pop) begin
            retire_q <= retire_q + 16'd1;
            if (entries[0].dest != '0) regfile_q[entries[0].dest] <= entries[0].data;
        end
    end

    // Ascending age scan: the youngest matching pending entry overrides older ones.
    always_comb begin
        rd_a = regfile_q[bus.rd_addr_a];
        rd_b = regfile_q[bus.rd_addr_b];
        for (int i = 0; i < DEPTH; i++) begin
            rd_a = (CW'(i) < count && entries[i].dest == bus.rd_addr_a) ? entries[i].data : rd_a;
            rd_b = (CW'(i) < count && entries[i].dest == bus.rd_addr_b) ? entries[i].data : rd_b;
        end
        rd_a = bus.rd_addr_a == '0 ? '0 : rd_a;
        rd_b = bus.rd_addr_b == '0 ? '0 : rd_b;
    end

    assign bus.rd_data_a    = rd_a;
    assign bus.rd_data_b    = rd_b;
    assign bus.buf_count    = count;
    assign bus.retire_count = retire_q;
endmodule
